// File: rtl/vr16_pkg.sv
// Shared VR16 definitions: word width, opcode map and the sequencer state encoding.
package vr16_pkg;

    localparam int WORD_W = 16;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_LO = 4'h1;
    localparam logic [3:0] OP_ALU_HI = 4'h7;
    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_STORE  = 4'h9;
    localparam logic [3:0] OP_BRANCH = 4'hA;
    localparam logic [3:0] OP_JUMP   = 4'hB;
    localparam logic [3:0] OP_HALT   = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_DONE   = 4'd6,
        S_HALT   = 4'd7,
        S_FAULT  = 4'd8
    } seq_state_t;

    function automatic logic [WORD_W-1:0] sext8(input logic [7:0] v);
        return {{(WORD_W-8){v[7]}}, v};
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer bus: run control, imem/ALU/dmem handshakes and retirement status.
interface instr_sequencer_if;
    import vr16_pkg::*;

    logic              run;
    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ack;
    logic [WORD_W-1:0] imem_rdata;
    logic              alu_start;
    logic              alu_done;
    logic              dmem_req;
    logic              dmem_we;
    logic              dmem_ack;
    logic              cond_flag;
    logic              rf_we;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] ir;
    logic              ins_done;
    logic              halted;
    logic              fault;

    modport master (
        input  run, imem_ack, imem_rdata, alu_done, dmem_ack, cond_flag,
        output imem_req, imem_addr, alu_start, dmem_req, dmem_we, rf_we,
               pc, ir, ins_done, halted, fault
    );

    modport slave (
        output run, imem_ack, imem_rdata, alu_done, dmem_ack, cond_flag,
        input  imem_req, imem_addr, alu_start, dmem_req, dmem_we, rf_we,
               pc, ir, ins_done, halted, fault
    );

endinterface

// File: rtl/instr_sequencer_wait_timer.sv
// Handshake watchdog: counts cycles while enabled and flags the last permitted wait cycle.
module wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

    logic [7:0] r_count;

    // Saturate at LAST so a stalled enable never wraps back to a "fresh" count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = i_en && (r_count == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// VR16 fetch/decode/execute controller: owns PC/IR, drives the memory and ALU handshakes,
// and pulses ins_done once per retired instruction.
module instr_sequencer
    import vr16_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter int                MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    instr_sequencer_if.master  bus
);

    seq_state_t        r_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_pc_next;
    logic [WORD_W-1:0] r_ir;
    logic              r_imem_req;
    logic              r_alu_start;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic              r_rf_we;
    logic              r_ins_done;
    logic              r_halted;
    logic              r_fault;

    logic       w_waiting;
    logic       w_expired;
    logic [3:0] w_op;

    assign w_op      = r_ir[15:12];
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_MEM);

    // Waiting states are never adjacent, so clearing outside them restarts the count on every entry.
    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (!w_waiting),
        .i_en      (w_waiting),
        .o_expired (w_expired)
    );

    // NOTE: every state/output register is assigned with <= so all updates in one edge see the old values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_pc_next   <= RESET_PC;
            r_ir        <= '0;
            r_imem_req  <= 1'b0;
            r_alu_start <= 1'b0;
            r_dmem_req  <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_rf_we     <= 1'b0;
            r_ins_done  <= 1'b0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        r_ir       <= bus.imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end else if (w_expired) begin
                        r_imem_req <= 1'b0;
                        r_fault    <= 1'b1;
                        r_state    <= S_FAULT;
                    end
                end
                S_DECODE: begin
                    r_pc_next <= r_pc + 16'd1;
                    if (w_op == OP_NOP) begin
                        r_ins_done <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (is_alu_op(w_op)) begin
                        r_alu_start <= 1'b1;
                        r_state     <= S_EXEC;
                    end else if ((w_op == OP_LOAD) || (w_op == OP_STORE)) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= (w_op == OP_STORE);
                        r_state    <= S_MEM;
                    end else if ((w_op == OP_BRANCH) || (w_op == OP_JUMP)) begin
                        if ((w_op == OP_JUMP) || bus.cond_flag) begin
                            r_pc_next <= r_pc + sext8(r_ir[7:0]);
                        end
                        r_ins_done <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (w_op == OP_HALT) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_fault <= 1'b1;
                        r_state <= S_FAULT;
                    end
                end
                S_EXEC: begin
                    if (bus.alu_done) begin
                        r_rf_we <= 1'b1;
                        r_state <= S_WB;
                    end else if (w_expired) begin
                        r_fault <= 1'b1;
                        r_state <= S_FAULT;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (r_dmem_we) begin
                            r_ins_done <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_rf_we <= 1'b1;
                            r_state <= S_WB;
                        end
                    end else if (w_expired) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_fault    <= 1'b1;
                        r_state    <= S_FAULT;
                    end
                end
                S_WB: begin
                    r_rf_we    <= 1'b0;
                    r_ins_done <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_ins_done <= 1'b0;
                    r_pc       <= r_pc_next;
                    if (bus.run) begin
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT, S_FAULT: begin
                    r_state <= r_state;
                end
                default: begin
                    r_imem_req <= 1'b0;
                    r_dmem_req <= 1'b0;
                    r_dmem_we  <= 1'b0;
                    r_rf_we    <= 1'b0;
                    r_ins_done <= 1'b0;
                    r_fault    <= 1'b1;
                    r_state    <= S_FAULT;
                end
            endcase
        end
    end

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_pc;
    assign bus.alu_start = r_alu_start;
    assign bus.dmem_req  = r_dmem_req;
    assign bus.dmem_we   = r_dmem_we;
    assign bus.rf_we     = r_rf_we;
    assign bus.pc        = r_pc;
    assign bus.ir        = r_ir;
    assign bus.ins_done  = r_ins_done;
    assign bus.halted    = r_halted;
    assign bus.fault     = r_fault;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-instruction timing/strobe expectations are
// derived from the latency and wait rules with plain arithmetic.
module tb_instr_sequencer;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          MAX_WAIT = 15;
    localparam int          K_DONE   = 0;
    localparam int          K_HALT   = 1;
    localparam int          K_FAULT  = 2;

    logic        clk = 1'b0;
    logic        reset;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_pc;

    instr_sequencer_if bus();

    instr_sequencer #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {imem_req, alu_start, dmem_req, dmem_we, rf_we, ins_done, halted, fault}
    function automatic logic [7:0] outs();
        return {bus.imem_req, bus.alu_start, bus.dmem_req, bus.dmem_we,
                bus.rf_we, bus.ins_done, bus.halted, bus.fault};
    endfunction

    task automatic clear_acks();
        bus.imem_ack = 1'b0;
        bus.alu_done = 1'b0;
        bus.dmem_ack = 1'b0;
    endtask

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        clear_acks();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_pc  = RESET_PC;
    endtask

    // Runs one instruction: imem_dly/unit_dly are extra wait cycles before the ack/done.
    task automatic run_instr(input logic [15:0] instr, input int imem_dly, input int unit_dly,
                             input logic cond, input bit drop_run);
        logic [3:0]  op;
        logic [15:0] exp_pc_next;
        int t, t_end, unit_t, e_kind, o_kind, off;
        int exp_req, exp_start, exp_dreq, exp_we, exp_rf;
        int n_req, n_start, n_dreq, n_we, n_rf, n_exec;
        bit ok, finished, exec_seen;

        op          = instr[15:12];
        exp_pc_next = 16'(int'(m_pc) + 1);
        exp_start   = 0;
        exp_dreq    = 0;
        exp_we      = 0;
        exp_rf      = 0;
        exp_req     = (imem_dly >= MAX_WAIT) ? MAX_WAIT : imem_dly + 1;
        if (imem_dly >= MAX_WAIT) begin
            e_kind = K_FAULT;
            t_end  = MAX_WAIT;
        end else begin
            t_end = imem_dly + 2;
            if (op == 4'h0) begin
                e_kind = K_DONE;
            end else if (op <= 4'h9) begin
                unit_t = t_end + ((unit_dly >= MAX_WAIT) ? MAX_WAIT : unit_dly + 1);
                if (op <= 4'h7) exp_start = 1;
                else exp_dreq = (unit_dly >= MAX_WAIT) ? MAX_WAIT : unit_dly + 1;
                if (op == 4'h9) exp_we = exp_dreq;
                if (unit_dly >= MAX_WAIT) begin
                    e_kind = K_FAULT;
                    t_end  = unit_t;
                end else if (op == 4'h9) begin
                    e_kind = K_DONE;
                    t_end  = unit_t;
                end else begin
                    e_kind = K_DONE;
                    t_end  = unit_t + 1;
                    exp_rf = 1;
                end
            end else if ((op == 4'hA) || (op == 4'hB)) begin
                e_kind = K_DONE;
                if ((op == 4'hB) || cond) begin
                    off = int'(instr[7:0]);
                    if (off > 127) off -= 256;
                    exp_pc_next = 16'(int'(m_pc) + off);
                end
            end else if (op == 4'hF) begin
                e_kind = K_HALT;
            end else begin
                e_kind = K_FAULT;
            end
        end

        wait_fetch(ok);
        check("fetch_start", 32'(bus.imem_req), 32'd1);
        if (!ok) return;
        check("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
        check("done_pulse_len", 32'(bus.ins_done), 32'd0);

        t = 0; n_req = 0; n_start = 0; n_dreq = 0; n_we = 0; n_rf = 0; n_exec = 0;
        finished = 1'b0; exec_seen = 1'b0;
        bus.imem_rdata = instr;
        bus.cond_flag  = cond;
        while (!finished && (t < 200)) begin
            if (bus.imem_req)  n_req++;
            if (bus.alu_start) n_start++;
            if (bus.dmem_req)  n_dreq++;
            if (bus.dmem_we)   n_we++;
            if (bus.rf_we)     n_rf++;
            if (bus.ins_done || bus.halted || bus.fault) begin
                finished = 1'b1;
            end else begin
                if (bus.alu_start) exec_seen = 1'b1;
                bus.imem_ack = bus.imem_req && (n_req == imem_dly + 1);
                bus.dmem_ack = bus.dmem_req && (n_dreq == unit_dly + 1);
                bus.alu_done = exec_seen && (n_exec == unit_dly);
                if (exec_seen) n_exec++;
                if (drop_run && (t == 1)) bus.run = 1'b0;
                @(negedge clk);
                t++;
            end
        end
        clear_acks();

        o_kind = bus.ins_done ? K_DONE : (bus.halted ? K_HALT : K_FAULT);
        check("end_time", 32'(t), 32'(t_end));
        check("end_kind", 32'(o_kind), 32'(e_kind));
        check("imem_req_cycles", 32'(n_req), 32'(exp_req));
        check("alu_start_cycles", 32'(n_start), 32'(exp_start));
        check("dmem_req_cycles", 32'(n_dreq), 32'(exp_dreq));
        check("dmem_we_cycles", 32'(n_we), 32'(exp_we));
        check("rf_we_cycles", 32'(n_rf), 32'(exp_rf));
        if (imem_dly < MAX_WAIT) check("ir", 32'(bus.ir), 32'(instr));
        if (e_kind != K_DONE) check("terminal_strobes", 32'(outs() & 8'hFC), 32'd0);
        if (e_kind == K_DONE) m_pc = exp_pc_next;
    endtask

    function automatic logic [15:0] jump_to(input logic [15:0] target);
        logic [15:0] delta;
        delta = target - m_pc;
        return {4'hB, 4'h0, delta[7:0]};
    endfunction

    initial begin
        bit ok;
        int n_bad;
        logic [3:0]  r_op;
        logic [15:0] r_instr;

        reset          = 1'b1;
        bus.run        = 1'b1;
        bus.imem_rdata = 16'h0000;
        bus.cond_flag  = 1'b0;
        clear_acks();
        m_pc = RESET_PC;

        #12;
        check("reset_strobes", 32'(outs()), 32'd0);
        check("reset_pc", 32'(bus.pc), 32'(RESET_PC));
        check("reset_ir", 32'(bus.ir), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back NOPs from RESET_PC, then the ALU case with a delayed done.
        repeat (4) run_instr(16'h0000, 0, 0, 1'b0, 1'b0);
        run_instr(16'h1234, 0, 2, 1'b0, 1'b0);

        // Branch/jump wrap cases.
        run_instr(jump_to(16'h0010), 0, 0, 1'b0, 1'b0);
        run_instr(16'hA0F0, 0, 0, 1'b1, 1'b0);
        run_instr(jump_to(16'h0010), 0, 0, 1'b0, 1'b0);
        run_instr(16'hA0F0, 0, 0, 1'b0, 1'b0);
        run_instr(jump_to(16'hFFFF), 0, 0, 1'b0, 1'b0);
        run_instr(16'hB001, 0, 0, 1'b0, 1'b0);

        // Memory ops and waits accepted on the last permitted cycle.
        run_instr(16'h9ABC, 0, 2, 1'b0, 1'b0);
        run_instr(16'h8001, 1, 1, 1'b0, 1'b0);
        run_instr(16'h0000, MAX_WAIT - 1, 0, 1'b0, 1'b0);
        run_instr(16'h5555, 0, MAX_WAIT - 1, 1'b0, 1'b0);
        run_instr(16'h3003, 0, 0, 1'b0, 1'b0);

        // run dropped mid-instruction: completes, then stays idle until run returns.
        run_instr(16'h8123, 1, 1, 1'b0, 1'b1);
        n_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.imem_req || bus.ins_done) n_bad++;
        end
        check("idle_after_run_drop", 32'(n_bad), 32'd0);
        bus.run = 1'b1;

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0:       r_op = 4'h0;
                1:       r_op = 4'(  $urandom_range(1, 7));
                2:       r_op = 4'h8;
                3:       r_op = 4'h9;
                4:       r_op = 4'hA;
                default: r_op = 4'hB;
            endcase
            r_instr = {r_op, 12'($urandom)};
            run_instr(r_instr, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom), 1'b0);
        end

        // Asynchronous reset during EXEC.
        wait_fetch(ok);
        check("rst_fetch", 32'(bus.imem_req), 32'd1);
        bus.imem_rdata = 16'h2345;
        bus.imem_ack   = 1'b1;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        @(negedge clk);
        check("rst_exec_alu_start", 32'(bus.alu_start), 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_async_strobes", 32'(outs()), 32'd0);
        check("rst_async_pc", 32'(bus.pc), 32'(RESET_PC));
        check("rst_async_ir", 32'(bus.ir), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_pc  = RESET_PC;
        run_instr(16'h0000, 0, 0, 1'b0, 1'b0);

        // Terminal conditions: fetch timeout, ALU timeout, illegal opcode, HALT.
        run_instr(16'h0000, MAX_WAIT, 0, 1'b0, 1'b0);
        do_reset();
        run_instr(16'h3000, 0, MAX_WAIT, 1'b0, 1'b0);
        do_reset();
        run_instr(16'hC000, 0, 0, 1'b0, 1'b0);
        do_reset();
        run_instr(16'hF000, 0, 0, 1'b0, 1'b0);
        n_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.imem_req || bus.ins_done || !bus.halted) n_bad++;
        end
        check("halt_stays_quiet", 32'(n_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
